// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bundle between the datapath (master) and the responder (slave).
// Handshake: the master holds req with wr/be/addr/wdata; the slave takes it only while idle
// (busy=0). Each accepted request gets exactly one single-cycle ready strobe, qualifying rdata and err.
interface data_mem_if;
  logic        req;
  logic        wr;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        ready;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, wr, be, addr, wdata,
    input  busy, ready, rdata, err
  );

  modport slave (
    input  req, wr, be, addr, wdata,
    output busy, ready, rdata, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory with a fixed-latency request/ready handshake and
// misalignment / range fault reporting for the MIPS core's load/store port.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  data_mem_if.slave   bus,
  output logic [1:0]  dbg_state_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0]   offset;
  logic [AW-1:0] word_idx;
  logic          misaligned;
  logic          out_of_range;
  logic          fault;
  logic          do_write;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          wr_d    = bus.wr;
          be_d    = bus.be;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      be_q    <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Unsigned subtraction makes addresses below BASE_ADDR wrap high and land in the range fault.
  assign offset       = addr_q - BASE_ADDR;
  assign word_idx     = offset[AW+1:2];
  assign misaligned   = |addr_q[1:0];
  assign out_of_range = (offset >> (AW + 2)) != 32'd0;
  assign fault        = misaligned | out_of_range;

  // A reset landing on the response edge must not let the store through.
  assign do_write = (state_q == RESP) && wr_q && !fault && !rst;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem_q[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.ready   = (state_q == RESP);
  assign bus.err     = (state_q == RESP) && fault;
  assign bus.rdata   = ((state_q == RESP) && !wr_q && !fault) ? mem_q[word_idx] : 32'd0;
  assign dbg_state_o = state_q;

endmodule
